// File: rtl/cpu7_excp_ctl_pkg.sv
// Shared encodings for the cpu7 exception/return sequencer: ecodes, FSM states,
// event kinds and the one-hot strobe bundle sent to the CSR file.
package cpu7_excp_ctl_pkg;

    localparam int CNT_W = 4;

    typedef logic [5:0] ecode_t;

    localparam ecode_t ECODE_INT = 6'h00;
    localparam ecode_t ECODE_ALE = 6'h09;
    localparam ecode_t ECODE_INE = 6'h0D;
    localparam ecode_t ECODE_NONE = 6'h00;

    typedef enum logic [1:0] {
        EXCP_IDLE     = 2'd0,
        EXCP_FLUSH    = 2'd1,
        EXCP_REDIRECT = 2'd2
    } excp_state_e;

    // The kind decides which CSR supplies the redirect target.
    typedef enum logic [1:0] {
        KIND_NONE = 2'd0,
        KIND_EXC  = 2'd1,
        KIND_RET  = 2'd2
    } excp_kind_e;

    typedef struct packed {
        logic intr;
        logic ine;
        logic ale;
        logic ertn;
    } excp_strobe_t;

endpackage

// File: rtl/cpu7_excp_ctl_if.sv
// Bundle between execute-stage control, the CSR file and the exception sequencer.
// The sequencer itself connects through the slave modport.
interface cpu7_excp_ctl_if #(
    parameter int GRLEN = 32,
    parameter int NIRQ  = 8
);
    logic             valid_e;
    logic             ale_e;
    logic             illinst_e;
    logic             ertn_e;
    logic [GRLEN-1:0] pc_e;
    logic [GRLEN-1:0] badv_e;
    logic [NIRQ-1:0]  irq;
    logic             crmd_ie;
    logic [GRLEN-1:0] csr_eentry;
    logic [GRLEN-1:0] csr_era;

    logic             excp_int;
    logic             excp_ale;
    logic             excp_illinst;
    logic             excp_ertn;
    logic [GRLEN-1:0] excp_pc;
    logic [GRLEN-1:0] excp_badv;
    logic [5:0]       excp_ecode;
    logic [NIRQ-1:0]  irq_pending;
    logic             flush;
    logic             stall_ifu;
    logic             redirect_valid;
    logic [GRLEN-1:0] redirect_pc;

    modport slave (
        input  valid_e, ale_e, illinst_e, ertn_e, pc_e, badv_e, irq, crmd_ie,
               csr_eentry, csr_era,
        output excp_int, excp_ale, excp_illinst, excp_ertn, excp_pc, excp_badv,
               excp_ecode, irq_pending, flush, stall_ifu, redirect_valid, redirect_pc
    );

    modport master (
        output valid_e, ale_e, illinst_e, ertn_e, pc_e, badv_e, irq, crmd_ie,
               csr_eentry, csr_era,
        input  excp_int, excp_ale, excp_illinst, excp_ertn, excp_pc, excp_badv,
               excp_ecode, irq_pending, flush, stall_ifu, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/cpu7_irq_sync.sv
// Two-flop synchroniser for the asynchronous, level-sensitive interrupt lines.
module cpu7_irq_sync #(
    parameter int NIRQ = 8
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [NIRQ-1:0] i_irq,
    output logic [NIRQ-1:0] o_irq_pending
);

    logic [NIRQ-1:0] r_meta;
    logic [NIRQ-1:0] r_sync;

    // NOTE: non-blocking assignments keep r_sync one edge behind r_meta; blocking
    // ones would collapse the two stages into a single flop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_irq;
            r_sync <= r_meta;
        end
    end

    assign o_irq_pending = r_sync;

endmodule

// File: rtl/cpu7_excp_ctl.sv
// Exception/return sequencer: accepts one event from _e, strobes the CSR file,
// holds the front end through a fixed flush window, then redirects the PC.
module cpu7_excp_ctl
    import cpu7_excp_ctl_pkg::*;
#(
    parameter int GRLEN        = 32,
    parameter int NIRQ         = 8,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic           clk,
    input  logic           resetn,
    cpu7_excp_ctl_if.slave excp_bus
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    excp_state_e      r_state;
    excp_state_e      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    excp_kind_e       r_kind;
    ecode_t           r_ecode;
    logic [GRLEN-1:0] r_pc;
    logic [GRLEN-1:0] r_badv;
    excp_strobe_t     r_strobe;

    logic [NIRQ-1:0]  w_irq_pending;
    logic             w_int_req;
    logic             w_any_event;
    logic             w_accept;
    excp_strobe_t     w_win;
    excp_kind_e       w_win_kind;
    ecode_t           w_win_ecode;

    logic             w_flush;
    logic             w_stall_ifu;
    logic             w_redirect_valid;
    logic [GRLEN-1:0] w_redirect_pc;

    cpu7_irq_sync #(
        .NIRQ (NIRQ)
    ) u_irq_sync (
        .clk           (clk),
        .resetn        (resetn),
        .i_irq         (excp_bus.irq),
        .o_irq_pending (w_irq_pending)
    );

    assign w_int_req   = (|w_irq_pending) & excp_bus.crmd_ie;
    assign w_any_event = w_int_req | excp_bus.illinst_e | excp_bus.ale_e | excp_bus.ertn_e;
    // Only IDLE accepts, so stale _e flags during FLUSH/REDIRECT are ignored.
    assign w_accept    = (r_state == EXCP_IDLE) & excp_bus.valid_e & w_any_event;

    // Fixed priority: int > illinst > ale > ertn; losers die with the instruction.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves one unassigned, which would infer a latch.
        w_win       = '0;
        w_win_kind  = KIND_NONE;
        w_win_ecode = ECODE_NONE;
        if (w_int_req) begin
            w_win.intr  = 1'b1;
            w_win_kind  = KIND_EXC;
            w_win_ecode = ECODE_INT;
        end else if (excp_bus.illinst_e) begin
            w_win.ine   = 1'b1;
            w_win_kind  = KIND_EXC;
            w_win_ecode = ECODE_INE;
        end else if (excp_bus.ale_e) begin
            w_win.ale   = 1'b1;
            w_win_kind  = KIND_EXC;
            w_win_ecode = ECODE_ALE;
        end else if (excp_bus.ertn_e) begin
            w_win.ertn  = 1'b1;
            w_win_kind  = KIND_RET;
            w_win_ecode = ECODE_NONE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= EXCP_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            EXCP_IDLE:     if (w_accept) w_state_nxt = EXCP_FLUSH;
            EXCP_FLUSH:    if (r_cnt == '0) w_state_nxt = EXCP_REDIRECT;
            EXCP_REDIRECT: w_state_nxt = EXCP_IDLE;
            default:       w_state_nxt = EXCP_IDLE;
        endcase
    end

    // Event record and flush counter; strobes live exactly one cycle after accept.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt    <= '0;
            r_kind   <= KIND_NONE;
            r_ecode  <= ECODE_NONE;
            r_pc     <= '0;
            r_badv   <= '0;
            r_strobe <= '0;
        end else if (w_accept) begin
            r_cnt    <= CNT_LOAD;
            r_kind   <= w_win_kind;
            r_ecode  <= w_win_ecode;
            r_pc     <= excp_bus.pc_e;
            r_badv   <= excp_bus.badv_e;
            r_strobe <= w_win;
        end else begin
            r_strobe <= '0;
            if (r_state == EXCP_FLUSH && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // The redirect target is read live so it reflects the CSR update of this event.
    always_comb begin
        w_flush          = 1'b0;
        w_stall_ifu      = 1'b0;
        w_redirect_valid = 1'b0;
        w_redirect_pc    = '0;
        unique case (r_state)
            EXCP_FLUSH: begin
                w_flush     = 1'b1;
                w_stall_ifu = 1'b1;
            end
            EXCP_REDIRECT: begin
                w_stall_ifu      = 1'b1;
                w_redirect_valid = 1'b1;
                w_redirect_pc    = (r_kind == KIND_RET) ? excp_bus.csr_era
                                                        : excp_bus.csr_eentry;
            end
            default: ;
        endcase
    end

    assign excp_bus.excp_int       = r_strobe.intr;
    assign excp_bus.excp_illinst   = r_strobe.ine;
    assign excp_bus.excp_ale       = r_strobe.ale;
    assign excp_bus.excp_ertn      = r_strobe.ertn;
    assign excp_bus.excp_pc        = r_pc;
    assign excp_bus.excp_badv      = r_badv;
    assign excp_bus.excp_ecode     = r_ecode;
    assign excp_bus.irq_pending    = w_irq_pending;
    assign excp_bus.flush          = w_flush;
    assign excp_bus.stall_ifu      = w_stall_ifu;
    assign excp_bus.redirect_valid = w_redirect_valid;
    assign excp_bus.redirect_pc    = w_redirect_pc;

endmodule

// File: tb/tb_cpu7_excp_ctl.sv
// Directed bench for cpu7_excp_ctl with FLUSH_CYCLES=2 and hand-computed expectations.
module tb_cpu7_excp_ctl;

    localparam int GRLEN = 32;
    localparam int NIRQ  = 8;

    logic clk;
    logic resetn;
    int   n_vec;
    int   n_err;

    cpu7_excp_ctl_if #(.GRLEN(GRLEN), .NIRQ(NIRQ)) bus ();

    cpu7_excp_ctl #(
        .GRLEN        (GRLEN),
        .NIRQ         (NIRQ),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .excp_bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_e();
        bus.valid_e   = 1'b0;
        bus.ale_e     = 1'b0;
        bus.illinst_e = 1'b0;
        bus.ertn_e    = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".flush"},  64'(bus.flush), 64'd0);
        check({tag, ".stall"},  64'(bus.stall_ifu), 64'd0);
        check({tag, ".rv"},     64'(bus.redirect_valid), 64'd0);
        check({tag, ".rpc"},    64'(bus.redirect_pc), 64'd0);
    endtask

    logic [5:0] exp_ale_seq;
    logic [5:0] exp_flush_seq;
    logic [5:0] exp_rv_seq;

    initial begin
        n_vec = 0;
        n_err = 0;
        resetn = 1'b0;
        clear_e();
        bus.pc_e       = '0;
        bus.badv_e     = '0;
        bus.irq        = '0;
        bus.crmd_ie    = 1'b0;
        bus.csr_eentry = 32'h1C00_8000;
        bus.csr_era    = 32'h1C00_0040;

        // Reset state
        tick();
        tick();
        check("rst.strobes", 64'({bus.excp_int, bus.excp_illinst, bus.excp_ale, bus.excp_ertn}), 64'd0);
        check("rst.excp_pc", 64'(bus.excp_pc), 64'd0);
        check("rst.ecode", 64'(bus.excp_ecode), 64'd0);
        check("rst.irq_pending", 64'(bus.irq_pending), 64'd0);
        check_idle_outputs("rst");
        #2 resetn = 1'b1;
        tick();

        // Single ale: strobe, 2 flush cycles, redirect to EENTRY
        bus.valid_e = 1'b1;
        bus.ale_e   = 1'b1;
        bus.pc_e    = 32'h1C00_0010;
        bus.badv_e  = 32'h1C00_00F1;
        tick();
        clear_e();
        check("ale.c1.excp_ale", 64'(bus.excp_ale), 64'd1);
        check("ale.c1.other_strobes", 64'({bus.excp_int, bus.excp_illinst, bus.excp_ertn}), 64'd0);
        check("ale.c1.ecode", 64'(bus.excp_ecode), 64'h09);
        check("ale.c1.excp_pc", 64'(bus.excp_pc), 64'h1C00_0010);
        check("ale.c1.excp_badv", 64'(bus.excp_badv), 64'h1C00_00F1);
        check("ale.c1.flush", 64'(bus.flush), 64'd1);
        check("ale.c1.stall", 64'(bus.stall_ifu), 64'd1);
        check("ale.c1.rv", 64'(bus.redirect_valid), 64'd0);
        tick();
        check("ale.c2.excp_ale", 64'(bus.excp_ale), 64'd0);
        check("ale.c2.flush", 64'(bus.flush), 64'd1);
        check("ale.c2.rv", 64'(bus.redirect_valid), 64'd0);
        tick();
        check("ale.c3.flush", 64'(bus.flush), 64'd0);
        check("ale.c3.stall", 64'(bus.stall_ifu), 64'd1);
        check("ale.c3.rv", 64'(bus.redirect_valid), 64'd1);
        check("ale.c3.rpc", 64'(bus.redirect_pc), 64'h1C00_8000);
        tick();
        check_idle_outputs("ale.c4");

        // Interrupt synchronisation, and no accept without valid_e
        bus.irq     = 8'h08;
        bus.crmd_ie = 1'b1;
        tick();
        check("irq.sync1", 64'(bus.irq_pending), 64'd0);
        tick();
        check("irq.sync2", 64'(bus.irq_pending), 64'h08);
        tick();
        check("irq.novalid.flush", 64'(bus.flush), 64'd0);
        check("irq.novalid.excp_int", 64'(bus.excp_int), 64'd0);

        // int beats illinst and ale; badv latched anyway
        bus.valid_e   = 1'b1;
        bus.ale_e     = 1'b1;
        bus.illinst_e = 1'b1;
        bus.pc_e      = 32'h1C00_0020;
        bus.badv_e    = 32'h1C00_0033;
        tick();
        clear_e();
        check("int.excp_int", 64'(bus.excp_int), 64'd1);
        check("int.ale_ine", 64'({bus.excp_ale, bus.excp_illinst}), 64'd0);
        check("int.ecode", 64'(bus.excp_ecode), 64'h00);
        check("int.excp_pc", 64'(bus.excp_pc), 64'h1C00_0020);
        check("int.excp_badv", 64'(bus.excp_badv), 64'h1C00_0033);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("int.later.strobes", 64'({bus.excp_int, bus.excp_illinst, bus.excp_ale}), 64'd0);
        end
        check("int.rv", 64'(bus.redirect_valid), 64'd1);
        check("int.rpc", 64'(bus.redirect_pc), 64'h1C00_8000);
        tick();

        // Same stimulus with IE clear: illinst wins
        bus.crmd_ie   = 1'b0;
        bus.valid_e   = 1'b1;
        bus.ale_e     = 1'b1;
        bus.illinst_e = 1'b1;
        bus.pc_e      = 32'h1C00_0024;
        tick();
        clear_e();
        check("ine.excp_illinst", 64'(bus.excp_illinst), 64'd1);
        check("ine.int_ale", 64'({bus.excp_int, bus.excp_ale}), 64'd0);
        check("ine.ecode", 64'(bus.excp_ecode), 64'h0D);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ine.later.ale", 64'(bus.excp_ale), 64'd0);
        end
        bus.irq = '0;

        // ertn redirects to ERA
        bus.valid_e = 1'b1;
        bus.ertn_e  = 1'b1;
        bus.pc_e    = 32'h1C00_0100;
        tick();
        clear_e();
        check("ertn.strobe", 64'(bus.excp_ertn), 64'd1);
        check("ertn.ecode", 64'(bus.excp_ecode), 64'h00);
        tick();
        check("ertn.c2.strobe", 64'(bus.excp_ertn), 64'd0);
        tick();
        check("ertn.rv", 64'(bus.redirect_valid), 64'd1);
        check("ertn.rpc", 64'(bus.redirect_pc), 64'h1C00_0040);
        tick();
        check_idle_outputs("ertn.c4");

        // ale held 6 cycles: accepts after edges 1 and 5 only
        exp_ale_seq   = 6'b010001;
        exp_flush_seq = 6'b110011;
        exp_rv_seq    = 6'b000100;
        bus.valid_e = 1'b1;
        bus.ale_e   = 1'b1;
        bus.pc_e    = 32'h1C00_0200;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("b2b.excp_ale", 64'(bus.excp_ale), 64'(exp_ale_seq[i]));
            check("b2b.flush", 64'(bus.flush), 64'(exp_flush_seq[i]));
            check("b2b.rv", 64'(bus.redirect_valid), 64'(exp_rv_seq[i]));
            check("b2b.onehot", 64'(32'(bus.excp_int) + 32'(bus.excp_illinst)
                                    + 32'(bus.excp_ale) + 32'(bus.excp_ertn)),
                  64'(exp_ale_seq[i]));
        end
        clear_e();
        for (int i = 0; i < 3; i++) tick();
        check_idle_outputs("b2b.end");

        // Reset mid-FLUSH clears everything asynchronously and drops the redirect
        bus.valid_e = 1'b1;
        bus.ale_e   = 1'b1;
        bus.pc_e    = 32'h1C00_0300;
        bus.badv_e  = 32'h1C00_0301;
        tick();
        clear_e();
        check("rstmid.pre.flush", 64'(bus.flush), 64'd1);
        #2 resetn = 1'b0;
        #1;
        check("rstmid.flush", 64'(bus.flush), 64'd0);
        check("rstmid.stall", 64'(bus.stall_ifu), 64'd0);
        check("rstmid.excp_ale", 64'(bus.excp_ale), 64'd0);
        check("rstmid.excp_pc", 64'(bus.excp_pc), 64'd0);
        check("rstmid.excp_badv", 64'(bus.excp_badv), 64'd0);
        check("rstmid.ecode", 64'(bus.excp_ecode), 64'd0);
        tick();
        #2 resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rstmid.after.rv", 64'(bus.redirect_valid), 64'd0);
            check("rstmid.after.flush", 64'(bus.flush), 64'd0);
        end
        bus.valid_e = 1'b1;
        bus.ale_e   = 1'b1;
        tick();
        clear_e();
        check("rstmid.reaccept", 64'(bus.excp_ale), 64'd1);
        for (int i = 0; i < 3; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
